// File: rtl/vga_write_arbiter.sv
// rtl/vga_write_arbiter.sv - round-robin burst arbiter for the shared VGA framebuffer write port
//
// Optional feature macro: VGA_ARB_CLEAR_PRIORITY_EN
//   defined   : requester 0 (screen clear) wins every IDLE arbitration it requests in
//   undefined : pure round-robin for all requesters
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   req        per-requester pixel valid / request
//   req_last   final pixel of the requester's stream
//   req_x      packed x coordinates, requester i at [i*X_W +: X_W]
//   req_y      packed y coordinates, requester i at [i*Y_W +: Y_W]
//   req_color  packed colours, requester i at [i*COLOR_W +: COLOR_W]
//   gnt        registered one-hot grant, zero when idle
//   vga_x      registered pixel x to vga_adapter
//   vga_y      registered pixel y to vga_adapter
//   vga_color  registered colour to vga_adapter
//   vga_plot   registered write enable to vga_adapter
//   busy       high while a burst is in progress
module vga_write_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COLOR_W   = 3,
  parameter int MAX_BURST = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*X_W-1:0]   req_x,
  input  logic [NUM_REQ*Y_W-1:0]   req_y,
  input  logic [NUM_REQ*COLOR_W-1:0] req_color,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COLOR_W-1:0]       vga_color,
  output logic                     vga_plot,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [IDX_W-1:0]   gidx, gidx_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [X_W-1:0]     x_n;
  logic [Y_W-1:0]     y_n;
  logic [COLOR_W-1:0] color_n;
  logic               plot_n;
  logic [IDX_W-1:0]   win;
  logic               found;

  // Round-robin winner: first requester above the last winner, wrapping.
  always_comb begin
    int idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
`ifdef VGA_ARB_CLEAR_PRIORITY_EN
    // Screen clear overrides the rotation whenever it is asking.
    if (req[0]) begin
      found = 1'b1;
      win   = '0;
    end
`endif
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    gidx_n  = gidx;
    ptr_n   = ptr;
    cnt_n   = cnt;
    x_n     = vga_x;
    y_n     = vga_y;
    color_n = vga_color;
    plot_n  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = BURST;
          gidx_n  = win;
          ptr_n   = win;
          cnt_n   = '0;
          for (int i = 0; i < NUM_REQ; i++) gnt_n[i] = (i == int'(win));
        end
      end
      BURST: begin
        if (req[gidx]) begin
          plot_n  = 1'b1;
          x_n     = req_x[int'(gidx)*X_W +: X_W];
          y_n     = req_y[int'(gidx)*Y_W +: Y_W];
          color_n = req_color[int'(gidx)*COLOR_W +: COLOR_W];
          cnt_n   = cnt + CNT_W'(1);
          if (req_last[gidx] || (cnt_n == CNT_W'(MAX_BURST))) begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end else begin
          // Requester dropped out mid-stream: release without plotting.
          state_n = IDLE;
          gnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gidx      <= '0;
      ptr       <= IDX_W'(NUM_REQ - 1);
      cnt       <= '0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
      vga_plot  <= 1'b0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gidx      <= gidx_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      vga_x     <= x_n;
      vga_y     <= y_n;
      vga_color <= color_n;
      vga_plot  <= plot_n;
    end
  end

  assign busy = (state == BURST);

endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Shares the single VGA framebuffer write port (x, y, colour, plot) among several pixel-stream requesters: screen clear, ship sprite drawer and grid/enemy drawer.
- Sits between the drawing engines enabled by the game FSM and the vga_adapter.
- Grants one requester at a time for a bounded burst, using round-robin fairness.
- Registers the winning pixel onto the VGA port.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = screen clear).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOR_W, 3, colour width.
- MAX_BURST, 64, maximum pixels accepted per grant; must be ≥1.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester pixel valid / request.
- req_last  in  NUM_REQ  marks the requester's final pixel of its stream.
- req_x  in  NUM_REQ*X_W  packed x coordinates; requester i at [i*X_W +: X_W].
- req_y  in  NUM_REQ*Y_W  packed y coordinates.
- req_color  in  NUM_REQ*COLOR_W  packed colours.
- gnt  out  NUM_REQ  registered one-hot grant; all zero when idle.
- vga_x  out  X_W  registered pixel x to vga_adapter.
- vga_y  out  Y_W  registered pixel y.
- vga_color  out  COLOR_W  registered colour.
- vga_plot  out  1  registered write enable to vga_adapter.
- busy  out  1  high while in BURST.

Behaviour:
- Reset: state=IDLE, gnt=0, vga_x/vga_y/vga_color=0, vga_plot=0, busy=0, burst count=0, last-winner pointer=NUM_REQ-1 (so requester 0 wins first).
- Reset mid-burst: everything above is cleared on the next edge. No plot occurs in the cycle after reset is sampled.
- States: IDLE, BURST.
- IDLE:
  - If any req bit is high, pick the winner by round-robin: search upward from pointer+1, wrapping modulo NUM_REQ.
  - On the next edge: gnt=onehot(winner), pointer=winner, count=0, state=BURST.
  - Arbitration latency is 1 cycle. No pixel is accepted in IDLE.
- BURST, granted index g:
  - A pixel is accepted in every cycle where req[g]=1.
  - On the next edge: vga_x/y/color = requester g's fields, vga_plot=1, count++.
  - In cycles where no pixel is accepted, vga_plot=0 on the next edge. vga_* hold their last value.
  - Pixel-to-port latency is 1 cycle.
- Burst end: return to IDLE with gnt=0 on the next edge when any of the following holds:
  - req[g]=1 and req_last[g]=1 (last pixel is still plotted);
  - req[g]=0 (requester dropped; no plot that cycle);
  - the accepted pixel brings count to MAX_BURST.
- At least one dead cycle (IDLE) always separates consecutive bursts, including re-grant of the same requester.
- Requests from non-granted requesters are ignored during BURST. They are not queued and are re-evaluated in IDLE.
- Requesters must hold req and the pixel fields stable until they observe their gnt bit. Pixels are consumed only while gnt is high.
- gnt is always one-hot or zero. It never changes within a burst.
- busy = (state==BURST), registered together with gnt.

Optional Feature:
- Macro: VGA_ARB_CLEAR_PRIORITY_EN.
- Defined: at each IDLE arbitration, requester 0 (screen clear) wins whenever req[0]=1, regardless of the pointer. The pointer is still updated to the winner. No mid-burst preemption. Other requesters use round-robin as normal.
- Undefined: pure round-robin for all requesters.

Test Plan:
- Only req[1] high, streaming 4 pixels (x=10..13, y=5, colour=3'b100), req_last on the 4th:
  - gnt=3'b010 one cycle after req rises;
  - vga_plot high for 4 consecutive cycles, x=10..13 one cycle after each acceptance;
  - then gnt=0 and busy=0.
- req[2:0]=3'b111 held, each stream 2 pixels with req_last:
  - grant order after reset is 0,1,2,0;
  - exactly one idle cycle with gnt=0 between bursts.
- req[2] streams 70 pixels continuously with no req_last (MAX_BURST=64):
  - exactly 64 plots, 1 idle cycle, re-grant to 2 (only requester);
  - remaining 6 pixels plotted.
- Granted requester 0 drops req after 3 pixels:
  - 3 plots, no plot in the drop cycle;
  - IDLE next cycle; pending req[1] granted after that.
- Reset asserted during the 5th pixel of a burst:
  - next cycle gnt=0, vga_plot=0, vga_x=0;
  - next grant after release goes to requester 0 if requesting.
- With VGA_ARB_CLEAR_PRIORITY_EN defined, req=3'b111 held, 2-pixel streams:
  - grant order is 0,0,0…, with 1 and 2 starved while req[0] stays high;
  - after req[0] drops: 1 then 2.
  - Without the macro, the same stimulus gives 0,1,2.
